// File: rtl/hs_out_pkg.sv
// Shared types and constants for the high-speed output arbiter.
// Holds the header word layout, the arbiter state encoding and a header builder.
package hs_out_pkg;

    localparam int SRC_IDX_W = 2;
    localparam int LEN_W     = 12;
    localparam int DATA_W    = 16;

    localparam logic [1:0] HDR_TAG     = 2'b10;
    localparam int         HDR_TAG_LSB = 14;
    localparam int         HDR_SRC_LSB = 12;
    localparam int         HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_HEADER = 2'd2,
        ST_BODY   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] make_hdr(input logic [SRC_IDX_W-1:0] src,
                                                   input logic [LEN_W-1:0]     len);
        logic [DATA_W-1:0] w;
        w = '0;
        w[HDR_TAG_LSB +: 2]         = HDR_TAG;
        w[HDR_SRC_LSB +: SRC_IDX_W] = src;
        w[HDR_LEN_LSB +: LEN_W]     = len;
        return w;
    endfunction

endpackage

// File: rtl/hs_out_skid2.sv
// Two-entry first-word-fall-through register buffer feeding the I/O block.
// Head word visible the cycle after push; a push into a full buffer is taken only alongside a pop.
module hs_out_skid2
    import hs_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic [1:0]        count;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = ent0;
    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_dat;
                    else               ent1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // count stays put; the new word lands behind whatever remains
                    if (count == 2'd1) begin
                        ent0 <= push_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hs_out_arbiter.sv
// Round-robin, packet-granular share of the 16-bit output path among NUM_SRC sources.
// Header reaches dout 3 cycles after a request; sources are popped only while the output buffer can accept.
module hs_out_arbiter
    import hs_out_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                      IFCLK,
    input  logic                      RESET,
    input  logic                      EN,
    input  logic [NUM_SRC-1:0]        src_pkt_rdy,
    input  logic [NUM_SRC*LEN_W-1:0]  src_len,
    input  logic [NUM_SRC*DATA_W-1:0] src_dout,
    input  logic [NUM_SRC-1:0]        src_empty,
    output logic [NUM_SRC-1:0]        src_rd_en,
    output logic [DATA_W-1:0]         dout,
    output logic                      empty,
    input  logic                      rd_en,
    output logic                      busy,
    output logic [SRC_IDX_W-1:0]      cur_src,
    output logic [15:0]               pkt_count,
    output logic                      err_len
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_WORDS);

    state_t               state;
    logic [SRC_IDX_W-1:0] rr;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     remaining;

    logic                 sel_empty;
    logic [DATA_W-1:0]    sel_dat;
    logic [LEN_W-1:0]     sel_len;
    logic                 buf_full;
    logic                 push_ok;
    logic                 body_pop;
    logic                 push;
    logic [DATA_W-1:0]    push_dat;

    function automatic logic [SRC_IDX_W-1:0] rr_pick(input logic [SRC_IDX_W-1:0] last,
                                                     input logic [NUM_SRC-1:0]   req);
        logic [SRC_IDX_W-1:0] win;
        logic [SRC_IDX_W-1:0] idx;
        logic                 found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = SRC_IDX_W'((int'(last) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        sel_empty = 1'b1;
        sel_dat   = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_src == SRC_IDX_W'(i)) begin
                sel_empty = src_empty[i];
                sel_dat   = src_dout[i*DATA_W +: DATA_W];
                sel_len   = src_len[i*LEN_W +: LEN_W];
            end
        end
        push_ok  = !buf_full || rd_en;
        body_pop = (state == ST_BODY) && push_ok && !sel_empty;
        push     = body_pop || ((state == ST_HEADER) && push_ok);
        push_dat = (state == ST_HEADER) ? make_hdr(cur_src, len) : sel_dat;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rd_en[i] = body_pop && (cur_src == SRC_IDX_W'(i));
        end
    end

    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            rr        <= SRC_IDX_W'(NUM_SRC - 1);
            cur_src   <= '0;
            len       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            pkt_count <= '0;
            err_len   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // EN only gates new grants; a packet in flight always completes
                    if (EN && (|src_pkt_rdy)) begin
                        cur_src <= rr_pick(rr, src_pkt_rdy);
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if ((sel_len == '0) || (sel_len > MAX_LEN)) err_len <= 1'b1;
                    len   <= (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
                    busy  <= 1'b1;
                    state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (push_ok) begin
                        if (len == '0) begin
                            rr        <= cur_src;
                            pkt_count <= pkt_count + 16'd1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            remaining <= len;
                            state     <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (body_pop) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            rr        <= cur_src;
                            pkt_count <= pkt_count + 16'd1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hs_out_skid2 u_skid (
        .clk      (IFCLK),
        .rst      (RESET),
        .push     (push),
        .push_dat (push_dat),
        .pop      (rd_en),
        .dout     (dout),
        .empty    (empty),
        .full     (buf_full)
    );

endmodule

// File: tb/tb_hs_out_arbiter.sv
// Directed and randomized checks of hs_out_arbiter against a packet-level queue model.
module tb_hs_out_arbiter;

    localparam int NS   = 4;
    localparam int MAXW = 256;

    logic              IFCLK = 1'b0;
    logic              RESET;
    logic              EN;
    logic [NS-1:0]     src_pkt_rdy;
    logic [NS*12-1:0]  src_len;
    logic [NS*16-1:0]  src_dout;
    logic [NS-1:0]     src_empty;
    logic [NS-1:0]     src_rd_en;
    logic [15:0]       dout;
    logic              empty;
    logic              rd_en;
    logic              busy;
    logic [1:0]        cur_src;
    logic [15:0]       pkt_count;
    logic              err_len;

    hs_out_arbiter #(.NUM_SRC(NS), .MAX_PKT_WORDS(MAXW)) dut (
        .IFCLK       (IFCLK),
        .RESET       (RESET),
        .EN          (EN),
        .src_pkt_rdy (src_pkt_rdy),
        .src_len     (src_len),
        .src_dout    (src_dout),
        .src_empty   (src_empty),
        .src_rd_en   (src_rd_en),
        .dout        (dout),
        .empty       (empty),
        .rd_en       (rd_en),
        .busy        (busy),
        .cur_src     (cur_src),
        .pkt_count   (pkt_count),
        .err_len     (err_len)
    );

    always #5 IFCLK = ~IFCLK;

    int          compared   = 0;
    int          mismatched = 0;

    logic [15:0] src_q    [NS][$];
    int          pend_len [NS][$];
    logic [15:0] plan_dat [NS][$];
    int          plan_len [NS][$];
    logic [15:0] exp_q[$];
    logic [15:0] log_q[$];
    int          exp_total, got_total;
    int          m_rr, m_pkts;
    logic        m_err;
    int          pop_cnt   [NS];
    int          stall_cnt [NS];
    logic [NS-1:0] drv_empty;
    logic [NS-1:0] last_rd_en;
    int          rd_pct, stall_pct, rd_low_cnt;
    logic        busy_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (busy === 1'b1 && !busy_q && pend_len[cur_src].size() > 0)
            void'(pend_len[cur_src].pop_front());
        busy_q = (busy === 1'b1);
        for (int i = 0; i < NS; i++) begin
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) stall_cnt[i] = $urandom_range(3, 1);
            drv_empty[i] = (src_q[i].size() == 0) || (stall_cnt[i] > 0);
            if (stall_cnt[i] > 0) stall_cnt[i]--;
            src_pkt_rdy[i]      = (pend_len[i].size() > 0);
            src_len[i*12 +: 12] = (pend_len[i].size() > 0) ? 12'(pend_len[i][0]) : 12'h0;
            src_dout[i*16 +: 16] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0;
        end
        src_empty = drv_empty;
        if (rd_low_cnt > 0) begin
            rd_en = 1'b0;
            rd_low_cnt--;
        end else begin
            rd_en = ($urandom_range(99) < rd_pct);
        end
    endtask

    // Observe combinational outputs mid-cycle, then advance one clock and re-drive.
    task automatic tick();
        @(negedge IFCLK);
        last_rd_en = src_rd_en;
        check("src_rd_en_onehot", $countones(src_rd_en) <= 1, 1);
        for (int i = 0; i < NS; i++) begin
            if (src_rd_en[i]) begin
                check("src_pop_legal", drv_empty[i], 0);
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                pop_cnt[i]++;
            end
        end
        if (rd_en && !empty) begin
            log_q.push_back(dout);
            got_total++;
            if (exp_q.size() == 0) check("stream_extra", got_total, exp_total);
            else                   check("stream_word", dout, exp_q.pop_front());
        end
        @(posedge IFCLK);
        #1;
        drive();
    endtask

    task automatic add_pkt(input int s, input int len, input bit fixed);
        int          eff;
        logic [15:0] w;
        eff = (len > MAXW) ? MAXW : len;
        pend_len[s].push_back(len);
        plan_len[s].push_back(len);
        for (int k = 0; k < eff; k++) begin
            w = fixed ? 16'(32'h1111 * (k + 1)) : 16'($urandom);
            src_q[s].push_back(w);
            plan_dat[s].push_back(w);
        end
    endtask

    // Expected output: packets served round-robin from the last winner, header then body.
    task automatic plan();
        int pick, c, L, eff;
        for (int n = 0; n < 64; n++) begin
            pick = -1;
            for (int k = 1; k <= NS; k++) begin
                c = (m_rr + k) % NS;
                if (pick < 0 && plan_len[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            L   = plan_len[pick].pop_front();
            eff = (L > MAXW) ? MAXW : L;
            exp_q.push_back({2'b10, 2'(pick), 12'(eff)});
            exp_total++;
            for (int w = 0; w < eff; w++) begin
                exp_q.push_back(plan_dat[pick].pop_front());
                exp_total++;
            end
            m_rr = pick;
            m_pkts++;
            if (L == 0 || L > MAXW) m_err = 1'b1;
        end
    endtask

    function automatic int src_left();
        int t;
        t = 0;
        for (int i = 0; i < NS; i++) t += pend_len[i].size() + src_q[i].size();
        return t;
    endfunction

    task automatic run_round(input string tag, input int limit);
        int c;
        c = 0;
        while (c < limit && !(exp_q.size() == 0 && busy === 1'b0 && src_left() == 0)) begin
            tick();
            c++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) tick();
        check({tag, "_pkt_count"}, pkt_count, 16'(m_pkts));
        check({tag, "_err_len"}, err_len, m_err);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_src_left"}, src_left(), 0);
    endtask

    task automatic wait_pops(input int s, input int n, input int limit);
        int c;
        c = 0;
        while (pop_cnt[s] < n && c < limit) begin
            tick();
            c++;
        end
        check("wait_pops", pop_cnt[s] >= n, 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);
        check("rst_cur_src", cur_src, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_err_len", err_len, 0);
        check("rst_src_rd_en", src_rd_en, 0);
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            pend_len[i].delete();
            plan_dat[i].delete();
            plan_len[i].delete();
            pop_cnt[i]   = 0;
            stall_cnt[i] = 0;
        end
        exp_q.delete();
        log_q.delete();
        exp_total  = 0;
        got_total  = 0;
        m_rr       = NS - 1;
        m_pkts     = 0;
        m_err      = 1'b0;
        busy_q     = 1'b0;
        rd_low_cnt = 0;
        drive();
        repeat (2) @(posedge IFCLK);
        #1;
        RESET = 1'b0;
        drive();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, idx, c;
        RESET = 1'b0; EN = 1'b1; rd_en = 1'b0;
        src_pkt_rdy = '0; src_len = '0; src_dout = '0; src_empty = '1;
        rd_pct = 100; stall_pct = 0; rd_low_cnt = 0; busy_q = 1'b0;
        drv_empty = '1;
        #3;
        do_reset();

        // Single packet, latency and exact word stream
        add_pkt(0, 3, 1'b1);
        plan();
        drive();
        tick(); check("lat_c1_empty", empty, 1);
        tick(); check("lat_c2_empty", empty, 1);
        tick(); check("lat_c3_empty", empty, 0);
        check("lat_c3_hdr", dout, 16'h8003);
        run_round("single", 200);
        check("single_w0", log_q[0], 16'h8003);
        check("single_w1", log_q[1], 16'h1111);
        check("single_w2", log_q[2], 16'h2222);
        check("single_w3", log_q[3], 16'h3333);
        check("single_cnt", pkt_count, 1);

        // Two simultaneous requesters straight after reset
        do_reset();
        add_pkt(1, 2, 1'b0);
        add_pkt(2, 2, 1'b0);
        plan();
        drive();
        run_round("rr", 200);
        check("rr_first_hdr", log_q[0], 16'h9002);
        check("rr_second_hdr", log_q[3], 16'hA002);

        // Source runs dry for 5 cycles after the second body word
        p0 = pop_cnt[0];
        add_pkt(0, 4, 1'b0);
        plan();
        drive();
        wait_pops(0, p0 + 2, 100);
        stall_cnt[0] = 5;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_no_pop", last_rd_en, 0);
            check("stall_busy", busy, 1);
        end
        run_round("stall", 200);
        check("stall_body_pops", pop_cnt[0] - p0, 4);

        // Output backpressure for 10 cycles mid-body
        p0 = pop_cnt[3];
        add_pkt(3, 12, 1'b0);
        plan();
        drive();
        wait_pops(3, p0 + 3, 100);
        p0  = pop_cnt[3];
        idx = got_total;
        rd_low_cnt = 10;
        drive();
        repeat (10) tick();
        check("rdlow_src_pops_le2", (pop_cnt[3] - p0) <= 2, 1);
        check("rdlow_no_out", got_total, idx);
        check("rdlow_buffered", empty, 0);
        run_round("rdlow", 300);

        // Zero-length and over-length requests
        check("err_before_len0", err_len, 0);
        add_pkt(0, 0, 1'b0);
        plan();
        drive();
        run_round("len0", 100);
        check("len0_hdr", log_q[log_q.size() - 1], 16'h8000);
        idx = log_q.size();
        add_pkt(2, 300, 1'b0);
        plan();
        drive();
        run_round("len300", 2000);
        check("len300_hdr", log_q[idx], 16'hA100);
        check("len300_words", log_q.size() - idx, 257);

        // Randomized traffic with random backpressure and source gaps
        for (int r = 0; r < 6; r++) begin
            rd_pct    = $urandom_range(100, 40);
            stall_pct = $urandom_range(15, 0);
            for (int p = 0; p < $urandom_range(5, 1); p++)
                add_pkt($urandom_range(NS - 1), $urandom_range(20, 0), 1'b0);
            plan();
            drive();
            run_round("rand", 3000);
        end
        stall_pct = 0;
        rd_pct    = 100;

        // EN dropped mid-packet, then reset mid-packet
        do_reset();
        add_pkt(0, 6, 1'b0);
        add_pkt(1, 6, 1'b0);
        plan();
        drive();
        wait_pops(0, 1, 100);
        EN = 1'b0;
        c = 0;
        while (busy !== 1'b0 && c < 100) begin
            tick();
            c++;
        end
        check("en_pkt0_done", busy, 0);
        check("en_pkt0_count", pkt_count, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("en_no_grant", busy, 0);
        end
        EN = 1'b1;
        wait_pops(1, 2, 100);
        check("midrst_busy_before", busy, 1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
